// File: rtl/wr_req_arbiter.sv
// Round-robin write-request arbiter: grants one of MASTER_NUM masters, holds the
// captured request toward the slave until ack or watchdog expiry, then pulses ack/err.
module wr_req_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MASTER_NUM = 2,
  parameter int TIMEOUT    = 256
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [MASTER_NUM-1:0]          m_req,
  input  logic [MASTER_NUM*AWIDTH-1:0]   m_addr,
  input  logic [MASTER_NUM*DWIDTH-1:0]   m_wdata,
  output logic [MASTER_NUM-1:0]          m_ack,
  output logic [MASTER_NUM-1:0]          m_err,
  output logic [$clog2(MASTER_NUM)-1:0]  s_sel,
  output logic [AWIDTH-1:0]              s_addr,
  output logic [DWIDTH-1:0]              s_wdata,
  output logic                           s_req,
  input  logic                           s_ack
);
  localparam int SW = $clog2(MASTER_NUM);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [SW-1:0] SLAST = SW'(MASTER_NUM - 1);
  localparam logic [MASTER_NUM-1:0] ONE = {{(MASTER_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   last_grant;
  logic [SW-1:0]   winner;
  logic [TW-1:0]   timer;
  logic            tmo;

  logic [MASTER_NUM-1:0][AWIDTH-1:0] addr_a;
  logic [MASTER_NUM-1:0][DWIDTH-1:0] wdata_a;
  assign addr_a  = m_addr;
  assign wdata_a = m_wdata;

  // Scan upward from the master after the last grant, wrapping at MASTER_NUM.
  always_comb begin
    logic [SW-1:0] idx;
    logic          found;
    winner = '0;
    found  = 1'b0;
    idx    = last_grant;
    for (int k = 0; k < MASTER_NUM; k++) begin
      idx = (idx == SLAST) ? '0 : idx + 1'b1;
      if (!found && m_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && (timer == TLAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_grant <= SLAST;
      timer      <= '0;
      s_req      <= 1'b0;
      s_sel      <= '0;
      s_addr     <= '0;
      s_wdata    <= '0;
      m_ack      <= '0;
      m_err      <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_ack <= '0;
          m_err <= '0;
          if (|m_req) begin
            s_sel      <= winner;
            s_addr     <= addr_a[winner];
            s_wdata    <= wdata_a[winner];
            s_req      <= 1'b1;
            last_grant <= winner;
            timer      <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Ack wins over a coincident watchdog expiry.
          if (s_ack) begin
            s_req <= 1'b0;
            m_ack <= ONE << s_sel;
            state <= DONE;
          end else if (tmo) begin
            s_req <= 1'b0;
            m_err <= ONE << s_sel;
            state <= DONE;
          end else if (TIMEOUT != 0) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          // Dead cycle lets the winner drop m_req before re-arbitration.
          m_ack <= '0;
          m_err <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wr_req_arbiter.sv
// Directed bench: main instance with a long watchdog, second instance with TIMEOUT=4.
module tb_wr_req_arbiter;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  m_req, m_ack, m_err;
  logic [63:0] m_addr, m_wdata;
  logic [0:0]  s_sel;
  logic [31:0] s_addr, s_wdata;
  logic        s_req, s_ack;

  logic [1:0]  t_req, t_ack, t_err;
  logic [63:0] t_addr, t_wdata;
  logic [0:0]  t_sel;
  logic [31:0] t_saddr, t_swdata;
  logic        t_sreq, t_sack;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  wr_req_arbiter #(.AWIDTH(32), .DWIDTH(32), .MASTER_NUM(2), .TIMEOUT(256)) dut (
    .aclk(aclk), .aresetn(aresetn), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_req(s_req), .s_ack(s_ack));

  wr_req_arbiter #(.AWIDTH(32), .DWIDTH(32), .MASTER_NUM(2), .TIMEOUT(4)) dut_t (
    .aclk(aclk), .aresetn(aresetn), .m_req(t_req), .m_addr(t_addr), .m_wdata(t_wdata),
    .m_ack(t_ack), .m_err(t_err), .s_sel(t_sel), .s_addr(t_saddr), .s_wdata(t_swdata),
    .s_req(t_sreq), .s_ack(t_sack));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge aclk);
  endtask

  initial begin
    aresetn = 1'b0;
    m_req = '0; m_addr = '0; m_wdata = '0; s_ack = 1'b0;
    t_req = '0; t_addr = '0; t_wdata = '0; t_sack = 1'b0;
    nxt(); nxt();
    chk("rst_sreq", s_req, 0);
    chk("rst_sel", s_sel, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wdata", s_wdata, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    aresetn = 1'b1;

    // Single transfer from master 1
    nxt();
    m_req = 2'b10; m_addr[63:32] = 32'h1000; m_wdata[63:32] = 32'hDEADBEEF;
    nxt();
    chk("single_sreq", s_req, 1);
    chk("single_sel", s_sel, 1);
    chk("single_addr", s_addr, 32'h1000);
    chk("single_wdata", s_wdata, 32'hDEADBEEF);
    chk("single_noack", m_ack, 0);
    s_ack = 1'b1;
    nxt();
    chk("single_ack", m_ack, 2'b10);
    chk("single_sreq_done", s_req, 0);
    s_ack = 1'b0; m_req = 2'b00;
    nxt();
    chk("single_ack_pulse", m_ack, 0);
    chk("single_sreq_low", s_req, 0);

    // Round-robin with both masters requesting and immediate ack
    m_addr = {32'h0000_00B0, 32'h0000_00A0};
    m_wdata = {32'h1111_1111, 32'h0000_0000};
    m_req = 2'b11; s_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      nxt();
      chk($sformatf("rr_sreq%0d", i), s_req, (i % 3 == 0) ? 1 : 0);
      if (i % 3 == 0) chk($sformatf("rr_sel%0d", i), s_sel, (i / 3) % 2);
      if (i % 3 == 1) begin
        chk($sformatf("rr_ack%0d", i), m_ack, ((i / 3) % 2) ? 2'b10 : 2'b01);
        chk($sformatf("rr_addr%0d", i), s_addr, ((i / 3) % 2) ? 32'hB0 : 32'hA0);
      end
      if (i % 3 == 2) chk($sformatf("rr_ackoff%0d", i), m_ack, 0);
    end
    m_req = 2'b00; s_ack = 1'b0;

    // Captured data holds while master 0 changes inputs and drops its request
    nxt();
    m_req = 2'b01; m_addr[31:0] = 32'h2222; m_wdata[31:0] = 32'h12345678;
    nxt();
    chk("stab_sreq", s_req, 1);
    chk("stab_sel", s_sel, 0);
    m_req = 2'b00; m_addr[31:0] = 32'hFFFF; m_wdata[31:0] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk($sformatf("stab_hold_sreq%0d", i), s_req, 1);
      chk($sformatf("stab_hold_addr%0d", i), s_addr, 32'h2222);
      chk($sformatf("stab_hold_wdata%0d", i), s_wdata, 32'h12345678);
    end
    s_ack = 1'b1;
    nxt();
    chk("stab_ack", m_ack, 2'b01);
    chk("stab_addr_done", s_addr, 32'h2222);
    s_ack = 1'b0;
    nxt();
    chk("stab_ack_pulse", m_ack, 0);

    // Spurious ack in IDLE
    s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk($sformatf("spur_sreq%0d", i), s_req, 0);
      chk($sformatf("spur_ack%0d", i), m_ack, 0);
      chk($sformatf("spur_err%0d", i), m_err, 0);
      chk($sformatf("spur_addr%0d", i), s_addr, 32'h2222);
    end
    s_ack = 1'b0;

    // Reset mid-BUSY aborts; master 0 wins first afterwards
    m_req = 2'b10; m_addr[63:32] = 32'h3333;
    nxt();
    chk("rb_sreq", s_req, 1);
    chk("rb_sel", s_sel, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("rb_async_sreq", s_req, 0);
    chk("rb_async_addr", s_addr, 0);
    chk("rb_async_wdata", s_wdata, 0);
    chk("rb_async_sel", s_sel, 0);
    m_req = 2'b11;
    nxt();
    chk("rb_hold_ack", m_ack, 0);
    chk("rb_hold_err", m_err, 0);
    aresetn = 1'b1;
    nxt();
    chk("rb_first_sreq", s_req, 1);
    chk("rb_first_sel", s_sel, 0);
    chk("rb_first_ack", m_ack, 0);
    s_ack = 1'b1; m_req = 2'b00;
    nxt();
    chk("rb_ack", m_ack, 2'b01);
    s_ack = 1'b0;
    nxt();

    // Watchdog expiry on the TIMEOUT=4 instance
    t_req = 2'b01; t_addr[31:0] = 32'h4444;
    nxt();
    chk("to_sel", t_sel, 0);
    t_req = 2'b00;
    chk("to_sreq0", t_sreq, 1);
    for (int i = 1; i < 4; i++) begin
      nxt();
      chk($sformatf("to_sreq%0d", i), t_sreq, 1);
    end
    nxt();
    chk("to_sreq_drop", t_sreq, 0);
    chk("to_err", t_err, 2'b01);
    chk("to_noack", t_ack, 0);
    nxt();
    chk("to_err_pulse", t_err, 0);

    // Ack on the final watchdog cycle wins
    t_req = 2'b01;
    nxt();
    chk("tie_sreq", t_sreq, 1);
    t_req = 2'b00;
    nxt(); nxt(); nxt();
    chk("tie_sreq_last", t_sreq, 1);
    t_sack = 1'b1;
    nxt();
    chk("tie_ack", t_ack, 2'b01);
    chk("tie_noerr", t_err, 0);
    t_sack = 1'b0;
    nxt();
    chk("tie_ack_pulse", t_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
